pulse_event_queue: RTL and testbench

- Sits in the clkb domain, directly downstream of the clka-to-clkb pulse synchronizer.
- Consumes its stretched, synchronized level output (sig_b) and turns each rising edge into exactly one event.
- Tags each event with a free-running clkb timestamp and buffers it in a small show-ahead FIFO.
- Presents events to a local consumer over a valid/ready handshake; overflow is flagged sticky and lost events are counted.

---
 rtl/pulse_event_queue_if.sv | 20 ++
 rtl/pulse_event_queue.sv | 113 +++++++++++
 tb/tb_pulse_event_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_event_queue_if.sv
// Consumer-side event handshake: show-ahead head timestamp with valid/ready.
interface pulse_event_queue_if #(
  parameter int unsigned TS_WIDTH = 16
) ();
  logic                evt_valid;
  logic                evt_ready;
  logic [TS_WIDTH-1:0] evt_ts;

  modport master (
    output evt_valid,
    output evt_ts,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ts,
    output evt_ready
  );
endinterface

// File: rtl/pulse_event_queue.sv
// Turns rising edges of the synchronized sig_b level into timestamped events,
// buffered in a show-ahead FIFO with sticky overflow flag and saturating drop count.
module pulse_event_queue #(
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_WIDTH = 8
) (
  input  logic                          clkb,
  input  logic                          rst_n,
  input  logic                          sig_b,
  input  logic                          ts_clr,
  pulse_event_queue_if.master           evt,
  output logic [$clog2(FIFO_DEPTH):0]   evt_level,
  output logic                          ovf_flag,
  output logic [DROP_WIDTH-1:0]         drop_cnt,
  input  logic                          ovf_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  logic                  sig_b_d_q, sig_b_d_d;
  logic [TS_WIDTH-1:0]   ts_cnt_q, ts_cnt_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_flag_q, ovf_flag_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [TS_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   mem_d [FIFO_DEPTH];

  logic edge_det;
  logic full;
  logic valid;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    edge_det = sig_b & ~sig_b_d_q;
    full     = (level_q == DEPTH_L);
    valid    = (level_q != '0);
    pop      = valid & evt.evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok  = edge_det & (~full | pop);
    drop     = edge_det & full & ~pop;
  end

  always_comb begin
    sig_b_d_d = sig_b;
    ts_cnt_d  = ts_clr ? '0 : ts_cnt_q + TS_WIDTH'(1);
    wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q + LW'(push_ok) - LW'(pop);
  end

  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = ts_cnt_q;
    end
  end

  // A drop coinciding with ovf_clr restarts the count at one rather than zero.
  always_comb begin
    ovf_flag_d = ovf_flag_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_flag_d = 1'b1;
      if (ovf_clr) begin
        drop_cnt_d = DROP_WIDTH'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
      end
    end else if (ovf_clr) begin
      ovf_flag_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      sig_b_d_q  <= 1'b0;
      ts_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_flag_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sig_b_d_q  <= sig_b_d_d;
      ts_cnt_q   <= ts_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_flag_q <= ovf_flag_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: the head is only exposed while level is non-zero.
  always_ff @(posedge clkb) begin
    mem_q <= mem_d;
  end

  assign evt.evt_valid = valid;
  assign evt.evt_ts    = valid ? mem_q[rd_ptr_q] : '0;
  assign evt_level     = level_q;
  assign ovf_flag      = ovf_flag_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pulse_event_queue.sv
// Scoreboard bench for pulse_event_queue: stimulus queues expected timestamps,
// a negedge monitor pops and compares on every accepted handshake.
module tb_pulse_event_queue;

  logic       clkb;
  logic       rst_n;
  logic       sig_b;
  logic       ts_clr;
  logic       ovf_clr;
  logic [2:0] evt_level;
  logic       ovf_flag;
  logic [7:0] drop_cnt;

  pulse_event_queue_if #(.TS_WIDTH(16)) evt_if ();

  pulse_event_queue #(
    .TS_WIDTH  (16),
    .FIFO_DEPTH(4),
    .DROP_WIDTH(8)
  ) dut (
    .clkb     (clkb),
    .rst_n    (rst_n),
    .sig_b    (sig_b),
    .ts_clr   (ts_clr),
    .evt      (evt_if.master),
    .evt_level(evt_level),
    .ovf_flag (ovf_flag),
    .drop_cnt (drop_cnt),
    .ovf_clr  (ovf_clr)
  );

  initial begin
    clkb = 1'b0;
    forever #5 clkb = ~clkb;
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] now_ts = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clkb);
      if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h required=none", evt_if.evt_ts);
        end else begin
          e = sb.pop_front();
          check("pop_ts", {16'd0, evt_if.evt_ts}, {16'd0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clkb);
    #1;
    now_ts = now_ts + 16'd1;
  endtask

  task automatic sync_ts();
    ts_clr = 1'b1;
    tick();
    ts_clr = 1'b0;
    now_ts = '0;
  endtask

  task automatic wait_to(input logic [15:0] t);
    while (now_ts != t) tick();
  endtask

  task automatic pulse();
    sig_b = 1'b1;
    tick();
    sig_b = 1'b0;
    tick();
  endtask

  task automatic pulse_at(input logic [15:0] t);
    wait_to(t);
    pulse();
  endtask

  task automatic drain(input int n);
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sig_b = 1'b0;
    ts_clr = 1'b0;
    ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
    check("rst_ts",    {16'd0, evt_if.evt_ts},    32'd0);
    check("rst_level", {29'd0, evt_level},        32'd0);
    check("rst_flag",  {31'd0, ovf_flag},         32'd0);
    check("rst_drop",  {24'd0, drop_cnt},         32'd0);
    rst_n = 1'b1;

    // single edge at ts 5, sig_b held high six cycles
    sync_ts();
    wait_to(16'd5);
    sig_b = 1'b1;
    sb.push_back(16'd5);
    tick();
    check("t1_valid", {31'd0, evt_if.evt_valid}, 32'd1);
    check("t1_ts",    {16'd0, evt_if.evt_ts},    32'd5);
    check("t1_level", {29'd0, evt_level},        32'd1);
    for (int i = 0; i < 5; i++) tick();
    sig_b = 1'b0;
    check("t1_no_repeat", {29'd0, evt_level}, 32'd1);
    drain(1);
    check("t1_empty", {29'd0, evt_level}, 32'd0);

    // five pulses into a depth-4 FIFO
    sync_ts();
    pulse_at(16'd10); sb.push_back(16'd10);
    pulse_at(16'd20); sb.push_back(16'd20);
    pulse_at(16'd30); sb.push_back(16'd30);
    pulse_at(16'd40); sb.push_back(16'd40);
    check("t2_level4", {29'd0, evt_level}, 32'd4);
    check("t2_flag0",  {31'd0, ovf_flag},  32'd0);
    pulse_at(16'd50);
    check("t2_level", {29'd0, evt_level}, 32'd4);
    check("t2_flag",  {31'd0, ovf_flag},  32'd1);
    check("t2_drop",  {24'd0, drop_cnt},  32'd1);

    // full FIFO: pop and edge in the same cycle
    wait_to(16'd100);
    sig_b = 1'b1;
    evt_if.evt_ready = 1'b1;
    sb.push_back(16'd100);
    tick();
    sig_b = 1'b0;
    evt_if.evt_ready = 1'b0;
    check("t3_level", {29'd0, evt_level}, 32'd4);
    check("t3_flag",  {31'd0, ovf_flag},  32'd1);
    check("t3_drop",  {24'd0, drop_cnt},  32'd1);
    drain(4);
    check("t3_empty", {29'd0, evt_level}, 32'd0);

    // drop counter saturation and ovf_clr interaction
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_clr_flag", {31'd0, ovf_flag}, 32'd0);
    check("t4_clr_drop", {24'd0, drop_cnt}, 32'd0);
    sync_ts();
    pulse_at(16'd2); sb.push_back(16'd2);
    pulse_at(16'd4); sb.push_back(16'd4);
    pulse_at(16'd6); sb.push_back(16'd6);
    pulse_at(16'd8); sb.push_back(16'd8);
    for (int i = 0; i < 254; i++) pulse();
    check("t4_drop254", {24'd0, drop_cnt}, 32'd254);
    for (int i = 0; i < 3; i++) pulse();
    check("t4_drop_sat", {24'd0, drop_cnt}, 32'd255);
    check("t4_flag",     {31'd0, ovf_flag}, 32'd1);
    sig_b = 1'b1;
    ovf_clr = 1'b1;
    tick();
    sig_b = 1'b0;
    ovf_clr = 1'b0;
    check("t4_clrdrop_flag", {31'd0, ovf_flag}, 32'd1);
    check("t4_clrdrop_cnt",  {24'd0, drop_cnt}, 32'd1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_clr2_flag", {31'd0, ovf_flag}, 32'd0);
    check("t4_clr2_cnt",  {24'd0, drop_cnt}, 32'd0);
    check("t4_level",     {29'd0, evt_level}, 32'd4);
    drain(4);

    // timestamp wrap and ts_clr
    sync_ts();
    pulse_at(16'hFFFE); sb.push_back(16'hFFFE);
    pulse_at(16'h0001); sb.push_back(16'h0001);
    sync_ts();
    pulse(); sb.push_back(16'h0000);
    check("t5_level", {29'd0, evt_level}, 32'd3);
    drain(3);

    // reset mid-drain, sig_b high across release
    sync_ts();
    pulse_at(16'd3); sb.push_back(16'd3);
    pulse_at(16'd7); sb.push_back(16'd7);
    drain(1);
    check("t6_level1", {29'd0, evt_level}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t6_rst_valid", {31'd0, evt_if.evt_valid}, 32'd0);
    check("t6_rst_level", {29'd0, evt_level},        32'd0);
    check("t6_rst_flag",  {31'd0, ovf_flag},         32'd0);
    sig_b = 1'b1;
    tick();
    rst_n = 1'b1;
    sb.push_back(16'd0);
    tick();
    check("t6_new_ts",    {16'd0, evt_if.evt_ts}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t6_one_event", {29'd0, evt_level}, 32'd1);
    sig_b = 1'b0;
    drain(1);
    tick();
    check("t6_empty", {29'd0, evt_level}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
